// File: rtl/ring_read_ctrl_if.sv
// Handshake/bus bundle between the ring read controller and its surroundings
// (write-side pointer, Round tracker, read RAM and downstream stream).
interface ring_read_ctrl_if #(
  parameter int BufferWidth = 4,
  parameter int DataWidth   = 8
);
  logic [BufferWidth-1:0] W_Addr;
  logic                   Round;
  logic                   Pop;
  logic [BufferWidth-1:0] R_Addr;
  logic [DataWidth-1:0]   Mem_RData;
  logic [DataWidth-1:0]   Out_Data;
  logic                   Out_Valid;
  logic                   Out_Ready;
  logic                   Empty;
  logic [BufferWidth:0]   Count;

  modport master (
    input  W_Addr, Round, Mem_RData, Out_Ready,
    output Pop, R_Addr, Out_Data, Out_Valid, Empty, Count
  );

  modport slave (
    output W_Addr, Round, Mem_RData, Out_Ready,
    input  Pop, R_Addr, Out_Data, Out_Valid, Empty, Count
  );
endinterface

// File: rtl/ring_read_ctrl.sv
// Read side of a circular line buffer: issues RAM reads from R_Addr and
// streams returned words downstream through a 2-entry skid at 1 word/cycle.
module ring_read_ctrl #(
  parameter int BufferWidth = 4,
  parameter int DataWidth   = 8
) (
  input  logic             clk,
  input  logic             aclr,
  ring_read_ctrl_if.master bus
);

  typedef enum logic [1:0] {SkidEmpty, SkidOne, SkidTwo} skidState_t;

  localparam logic [BufferWidth:0] Depth = (BufferWidth+1)'(2**BufferWidth);

  skidState_t             r_state;
  skidState_t             w_nextState;
  logic [BufferWidth-1:0] r_rAddr;
  logic                   r_inFlight;
  logic [DataWidth-1:0]   r_head;
  logic [DataWidth-1:0]   r_tail;

  logic                   w_empty;
  logic [BufferWidth:0]   w_count;
  logic                   w_valid;
  logic                   w_deq;
  logic                   w_enq;
  logic                   w_pop;
  logic [1:0]             w_occ;
  logic [2:0]             w_pending;
  logic                   w_loadHeadMem;
  logic                   w_loadHeadTail;
  logic                   w_loadTail;

  assign w_empty = (bus.W_Addr == r_rAddr) && !bus.Round;
  assign w_count = bus.Round ? (Depth - {1'b0, r_rAddr} + {1'b0, bus.W_Addr})
                             : ({1'b0, bus.W_Addr} - {1'b0, r_rAddr});

  // A read may issue only if its word will find a free skid slot when it lands.
  assign w_valid   = (r_state != SkidEmpty);
  assign w_deq     = w_valid && bus.Out_Ready;
  assign w_enq     = r_inFlight;
  assign w_pending = {1'b0, w_occ} + {2'b00, r_inFlight} - {2'b00, w_deq};
  assign w_pop     = aclr && !w_empty && (w_pending < 3'd2);

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_state <= SkidEmpty;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      SkidEmpty: if (w_enq) w_nextState = SkidOne;
      SkidOne: begin
        if (w_enq && !w_deq)      w_nextState = SkidTwo;
        else if (w_deq && !w_enq) w_nextState = SkidEmpty;
      end
      SkidTwo:   if (w_deq) w_nextState = SkidOne;
      default:   w_nextState = SkidEmpty;
    endcase
  end

  always_comb begin
    w_occ          = 2'd0;
    w_loadHeadMem  = 1'b0;
    w_loadHeadTail = 1'b0;
    w_loadTail     = 1'b0;
    case (r_state)
      SkidEmpty: w_loadHeadMem = w_enq;
      SkidOne: begin
        w_occ         = 2'd1;
        w_loadHeadMem = w_enq && w_deq;
        w_loadTail    = w_enq && !w_deq;
      end
      SkidTwo: begin
        w_occ          = 2'd2;
        w_loadHeadTail = w_deq;
      end
      default: w_occ = 2'd0;
    endcase
  end

  // Read pointer, in-flight flag and skid storage; head is the output register.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_rAddr    <= '0;
      r_inFlight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_inFlight <= w_pop;
      if (w_pop) r_rAddr <= r_rAddr + BufferWidth'(1);
      if (w_loadHeadMem)       r_head <= bus.Mem_RData;
      else if (w_loadHeadTail) r_head <= r_tail;
      if (w_loadTail) r_tail <= bus.Mem_RData;
    end
  end

  assign bus.Pop       = w_pop;
  assign bus.R_Addr    = r_rAddr;
  assign bus.Out_Data  = r_head;
  assign bus.Out_Valid = w_valid;
  assign bus.Empty     = w_empty;
  assign bus.Count     = w_count;

endmodule

// File: tb/tb_ring_read_ctrl.sv
// Bench for ring_read_ctrl: RAM, write side and Round tracker are modelled from
// absolute word counts; a queue of issued reads predicts the output stream.
module tb_ring_read_ctrl;
  localparam int BW    = 4;
  localparam int DW    = 8;
  localparam int Depth = 16;

  logic clk  = 1'b0;
  logic aclr = 1'b1;

  ring_read_ctrl_if #(.BufferWidth(BW), .DataWidth(DW)) bus ();

  ring_read_ctrl #(.BufferWidth(BW), .DataWidth(DW)) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int unsigned wrCount  = 0;
  int unsigned rdCount  = 0;
  int unsigned deqCount = 0;
  int unsigned cyc      = 0;
  logic [DW-1:0] mem [Depth];

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   tag;
  } entry_t;
  entry_t pipeQ[$];

  function automatic logic [DW-1:0] wordAt(int unsigned n);
    return DW'(n * 37 + 11);
  endfunction

  // A word read at edge k is visible from edge k+1 until it is accepted.
  function automatic logic modelValid();
    return (pipeQ.size() > 0) && (pipeQ[0].tag + 1 <= cyc);
  endfunction

  // Write side and Round tracker expressed as absolute lap counts.
  assign bus.W_Addr = wrCount[BW-1:0];
  assign bus.Round  = (wrCount / Depth) != (rdCount / Depth);

  always @(posedge clk) bus.Mem_RData <= mem[bus.R_Addr];

  always @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      pipeQ.delete();
      rdCount  <= 0;
      deqCount <= 0;
    end else begin
      if (modelValid() && bus.Out_Ready) begin
        void'(pipeQ.pop_front());
        deqCount <= deqCount + 1;
      end
      cyc = cyc + 1;
      if (bus.Pop) begin
        pipeQ.push_back('{wordAt(rdCount), cyc});
        rdCount <= rdCount + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s at %0t: got=%0h want=%0h", name, $time, actual, expected);
    end
  endtask

  task automatic writeWords(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wrCount % Depth] = wordAt(wrCount);
      wrCount = wrCount + 1;
    end
  endtask

  task automatic applyStimulus(input int n, input logic ready);
    @(posedge clk);
    #1;
    writeWords(n);
    bus.Out_Ready = ready;
  endtask

  int unsigned avail;
  int          pend;
  logic        expPop;
  logic        mValid;

  // Per-cycle comparison of every output against the queue model.
  always @(negedge clk) begin
    if (aclr) begin
      avail  = wrCount - rdCount;
      mValid = modelValid();
      pend   = pipeQ.size() - ((mValid && bus.Out_Ready) ? 1 : 0);
      expPop = (avail != 0) && (pend < 2);
      checkOutput("pop", 32'(bus.Pop), 32'(expPop));
      checkOutput("r_addr", 32'(bus.R_Addr), rdCount % Depth);
      checkOutput("empty", 32'(bus.Empty), 32'(avail == 0));
      checkOutput("count", 32'(bus.Count), avail);
      checkOutput("out_valid", 32'(bus.Out_Valid), 32'(mValid));
      if (mValid) checkOutput("out_data", 32'(bus.Out_Data), 32'(pipeQ[0].data));
    end
  end

  initial begin
    for (int i = 0; i < Depth; i++) mem[i] = '0;
    bus.Out_Ready = 1'b0;
    #2 aclr = 1'b0;
    repeat (2) @(posedge clk);
    #1 aclr = 1'b1;

    // Empty buffer stays idle.
    applyStimulus(0, 1'b1);
    repeat (10) begin
      @(negedge clk);
      checkOutput("idle empty", 32'(bus.Empty), 32'd1);
      checkOutput("idle pop", 32'(bus.Pop), 32'd0);
      checkOutput("idle count", 32'(bus.Count), 32'd0);
      checkOutput("idle valid", 32'(bus.Out_Valid), 32'd0);
    end

    // Three words stream out two cycles after the first read.
    begin
      logic [3:0] popExp   [6] = '{1, 1, 1, 0, 0, 0};
      logic [3:0] addrExp  [6] = '{0, 1, 2, 3, 3, 3};
      logic [3:0] validExp [6] = '{0, 0, 1, 1, 1, 0};
      logic [7:0] dataExp  [6] = '{0, 0, 11, 48, 85, 0};
      applyStimulus(3, 1'b1);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        checkOutput("three pop", 32'(bus.Pop), 32'(popExp[i]));
        checkOutput("three r_addr", 32'(bus.R_Addr), 32'(addrExp[i]));
        checkOutput("three valid", 32'(bus.Out_Valid), 32'(validExp[i]));
        if (validExp[i] != 0) checkOutput("three data", 32'(bus.Out_Data), 32'(dataExp[i]));
      end
    end

    // Asynchronous reset in the middle of a stream.
    applyStimulus(5, 1'b1);
    repeat (2) @(posedge clk);
    #2 aclr = 1'b0;
    #1;
    checkOutput("async valid", 32'(bus.Out_Valid), 32'd0);
    checkOutput("async r_addr", 32'(bus.R_Addr), 32'd0);
    checkOutput("async pop", 32'(bus.Pop), 32'd0);
    wrCount = 0;
    @(posedge clk);
    #1 aclr = 1'b1;

    // Back-pressure: two reads fill the skid, then six more drain back to back.
    begin
      logic [3:0] popExp  [6] = '{1, 1, 0, 0, 0, 0};
      logic [3:0] addrExp [6] = '{0, 1, 2, 2, 2, 2};
      applyStimulus(8, 1'b0);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        checkOutput("stall pop", 32'(bus.Pop), 32'(popExp[i]));
        checkOutput("stall r_addr", 32'(bus.R_Addr), 32'(addrExp[i]));
      end
      checkOutput("stall valid", 32'(bus.Out_Valid), 32'd1);
      checkOutput("stall data", 32'(bus.Out_Data), 32'd11);
      applyStimulus(0, 1'b1);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        checkOutput("drain valid", 32'(bus.Out_Valid), (k < 8) ? 32'd1 : 32'd0);
      end
    end

    // Wrap of R_Addr from 14 through 0 while Round is set.
    applyStimulus(6, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("wrap start", 32'(bus.R_Addr), 32'd14);
    applyStimulus(4, 1'b1);
    @(negedge clk);
    checkOutput("wrap count", 32'(bus.Count), 32'd4);
    checkOutput("wrap round", 32'(bus.Round), 32'd1);
    begin
      logic [3:0] addrExp [4] = '{15, 0, 1, 2};
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checkOutput("wrap r_addr", 32'(bus.R_Addr), 32'(addrExp[i]));
      end
    end
    checkOutput("wrap empty", 32'(bus.Empty), 32'd1);
    repeat (5) @(negedge clk);

    // Full buffer, then random back-pressure with the writer refilling.
    applyStimulus(3, 1'b1);
    repeat (6) @(negedge clk);
    checkOutput("full r_addr", 32'(bus.R_Addr), 32'd5);
    applyStimulus(16, 1'b0);
    @(negedge clk);
    checkOutput("full empty", 32'(bus.Empty), 32'd0);
    checkOutput("full count", 32'(bus.Count), 32'd16);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      bus.Out_Ready = 1'($urandom_range(0, 1));
      if ((wrCount - rdCount < Depth) && ($urandom_range(0, 1) == 1)) writeWords(1);
    end
    bus.Out_Ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("all delivered", deqCount, wrCount);
    checkOutput("final empty", 32'(bus.Empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
